// File: rtl/i2c_fifo_tx.sv
// I2C write-only master: sends START, {addr,W}, then FIFO bytes until empty or NACK, then STOP.
// Every bus phase lasts QDIV clocks; a bit cell is four phases (SCL low, high, high, low).
module i2c_fifo_tx #(
    parameter int unsigned QDIV = 63
) (
    input  logic       clock,
    input  logic       sclr,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] fifo_q,
    input  logic       fifo_empty,
    output logic       fifo_rdreq,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       sda_i,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_LOAD,
        S_DATA,
        S_DATA_ACK,
        S_STOP
    } state_t;

    localparam logic [7:0] QLAST = 8'(QDIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  qcnt_q;
    logic [1:0]  phase_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic        ack_q;
    logic        nack_q;
    logic        done_q;

    logic        qend;
    logic        cell_end;
    logic        bit_scl;
    logic        timed;
    logic        shifting;
    logic        in_ack;

    assign qend     = (qcnt_q == QLAST);
    assign cell_end = qend && (phase_q == 2'd3);
    assign bit_scl  = (phase_q == 2'd1) || (phase_q == 2'd2);
    assign timed    = (state_q != S_IDLE) && (state_q != S_LOAD);
    assign shifting = (state_q == S_ADDR) || (state_q == S_DATA);
    assign in_ack   = (state_q == S_ADDR_ACK) || (state_q == S_DATA_ACK);

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign nack = nack_q;

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scl_o      = 1'b1;
        sda_o      = 1'b1;
        fifo_rdreq = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_START;
            end
            S_START: begin
                sda_o = (phase_q == 2'd0);
                if (qend && phase_q == 2'd1) state_d = S_ADDR;
            end
            S_ADDR: begin
                scl_o = bit_scl;
                sda_o = shift_q[7];
                if (cell_end && bitcnt_q == 3'd7) state_d = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl_o = bit_scl;
                if (cell_end) state_d = ack_q ? S_STOP : S_LOAD;
            end
            S_LOAD: begin
                scl_o      = 1'b0;
                fifo_rdreq = !fifo_empty;
                state_d    = fifo_empty ? S_STOP : S_DATA;
            end
            S_DATA: begin
                scl_o = bit_scl;
                sda_o = shift_q[7];
                if (cell_end && bitcnt_q == 3'd7) state_d = S_DATA_ACK;
            end
            S_DATA_ACK: begin
                scl_o = bit_scl;
                if (cell_end) state_d = ack_q ? S_STOP : S_LOAD;
            end
            S_STOP: begin
                scl_o = (phase_q != 2'd0);
                sda_o = (phase_q == 2'd2);
                if (qend && phase_q == 2'd2) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Phase/bit counters restart on every state change so each state begins at P0.
    always_ff @(posedge clock) begin
        if (sclr) begin
            qcnt_q   <= '0;
            phase_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_d != state_q) begin
                qcnt_q   <= '0;
                phase_q  <= '0;
                bitcnt_q <= '0;
            end else if (timed) begin
                if (qend) begin
                    qcnt_q  <= '0;
                    phase_q <= phase_q + 2'd1;
                    if (shifting && phase_q == 2'd3) bitcnt_q <= bitcnt_q + 3'd1;
                end else begin
                    qcnt_q <= qcnt_q + 8'd1;
                end
            end

            if (state_q == S_IDLE && start) begin
                shift_q <= {addr, 1'b0};
                nack_q  <= 1'b0;
            end else if (state_q == S_LOAD && !fifo_empty) begin
                shift_q <= fifo_q;
            end else if (shifting && cell_end) begin
                shift_q <= {shift_q[6:0], 1'b0};
            end

            if (in_ack && qend && phase_q == 2'd1) ack_q <= sda_i;
            if (in_ack && cell_end && ack_q) nack_q <= 1'b1;
            if (state_q == S_STOP && qend && phase_q == 2'd2) done_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_fifo_tx.sv
// Self-checking bench for i2c_fifo_tx: FIFO model, bus monitor/ACK slave, byte scoreboard.
`timescale 1ns/1ps
module tb_i2c_fifo_tx;

    logic       clock;
    logic       sclr;
    logic       start;
    logic [6:0] addr;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic       fifo_rdreq;
    logic       scl_o;
    logic       sda_o;
    logic       sda_i;
    logic       busy;
    logic       done;
    logic       nack;

    i2c_fifo_tx #(.QDIV(2)) dut (
        .clock      (clock),
        .sclr       (sclr),
        .start      (start),
        .addr       (addr),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .sda_i      (sda_i),
        .busy       (busy),
        .done       (done),
        .nack       (nack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Show-ahead FIFO model: head advanced only by DUT pops, tail only by the stimulus process.
    logic [7:0] fmem [0:15];
    int head = 0;
    int tail = 0;
    int rdreq_cnt = 0;
    int underflow_cnt = 0;
    int done_cnt = 0;

    assign fifo_empty = (head == tail);
    assign fifo_q     = fmem[head % 16];

    always @(posedge clock) begin
        if (fifo_rdreq === 1'b1) begin
            rdreq_cnt++;
            if (head != tail) head <= head + 1;
            else underflow_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    // Bus monitor and slave: bits committed on SCL fall, ACK pulled unless this byte is to be NACKed.
    int         nack_at = -1;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         obs_wr = 0;
    int         bitn = 0;
    int         nbyte = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       have_bit = 1'b0;
    logic       bit_v = 1'b0;
    logic       pull = 1'b0;
    logic [7:0] cur = '0;
    logic [7:0] obs_mem [0:63];

    assign sda_i = sda_o & ~pull;

    always @(negedge clock) begin
        if (prev_scl && scl_o && prev_sda && !sda_o) begin
            start_cnt++;
            bitn = 0;
            nbyte = 0;
            have_bit = 1'b0;
            pull = 1'b0;
        end else if (prev_scl && scl_o && !prev_sda && sda_o) begin
            stop_cnt++;
            have_bit = 1'b0;
            pull = 1'b0;
        end else if (!prev_scl && scl_o) begin
            have_bit = 1'b1;
            bit_v = sda_o & ~pull;
        end else if (prev_scl && !scl_o && have_bit) begin
            have_bit = 1'b0;
            if (bitn < 8) begin
                cur = {cur[6:0], bit_v};
                bitn++;
                if (bitn == 8) begin
                    obs_mem[obs_wr % 64] = cur;
                    obs_wr++;
                    pull = (nbyte != nack_at);
                end
            end else begin
                bitn = 0;
                nbyte++;
                pull = 1'b0;
            end
        end
        prev_scl = scl_o;
        prev_sda = sda_o;
    end

    int n_checks = 0;
    int n_fails = 0;
    int obs_rd = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_bytes(input string tag);
        logic [7:0] e;
        int i;
        i = 0;
        check({tag, "_nbytes"}, obs_wr - obs_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                check($sformatf("%s_byte%0d", tag, i), {24'h0, obs_mem[obs_rd % 64]}, {24'h0, e});
                obs_rd++;
            end else begin
                check($sformatf("%s_byte%0d_missing", tag, i), 32'hFFFF_FFFF, {24'h0, e});
            end
            i++;
        end
        obs_rd = obs_wr;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        fmem[tail % 16] = b;
        tail++;
    endtask

    task automatic pulse_start(input logic [6:0] a);
        addr  = a;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_done_seen"}, (k < 3000), 1);
        repeat (3) @(negedge clock);
    endtask

    typedef struct {
        string      name;
        logic [6:0] addr;
        int         n;
        logic [7:0] d [3];
        int         nack_at;
        int         exp_rd;
        logic       exp_nack;
        int         exp_left;
    } vec_t;

    vec_t vecs [4];
    int s_start, s_stop, s_rd, s_done;

    task automatic snap();
        s_start = start_cnt;
        s_stop  = stop_cnt;
        s_rd    = rdreq_cnt;
        s_done  = done_cnt;
    endtask

    task automatic run_vec(input vec_t v);
        tail = head;
        for (int i = 0; i < v.n; i++) fifo_push(v.d[i]);
        nack_at = v.nack_at;
        exp_q.push_back({v.addr, 1'b0});
        if (v.nack_at != 0) begin
            for (int i = 0; i < v.n; i++) begin
                exp_q.push_back(v.d[i]);
                if (v.nack_at == i + 1) break;
            end
        end
        snap();
        pulse_start(v.addr);
        check({v.name, "_busy"}, busy, 1'b1);
        wait_done(v.name);
        compare_bytes(v.name);
        check({v.name, "_starts"}, start_cnt - s_start, 1);
        check({v.name, "_stops"}, stop_cnt - s_stop, 1);
        check({v.name, "_rdreq"}, rdreq_cnt - s_rd, v.exp_rd);
        check({v.name, "_done_cnt"}, done_cnt - s_done, 1);
        check({v.name, "_nack"}, nack, v.exp_nack);
        check({v.name, "_idle"}, busy, 1'b0);
        check({v.name, "_fifo_left"}, tail - head, v.exp_left);
    endtask

    initial begin
        vecs[0] = '{"two_bytes",  7'h50, 2, '{8'hA5, 8'h3C, 8'h00}, -1, 2, 1'b0, 0};
        vecs[1] = '{"addr_nack",  7'h21, 1, '{8'h11, 8'h00, 8'h00},  0, 0, 1'b1, 1};
        vecs[2] = '{"empty_fifo", 7'h21, 0, '{8'h00, 8'h00, 8'h00}, -1, 0, 1'b0, 0};
        vecs[3] = '{"data_nack",  7'h3B, 3, '{8'h01, 8'h02, 8'h03},  2, 2, 1'b1, 1};

        sclr  = 1'b1;
        start = 1'b0;
        addr  = '0;
        repeat (3) @(negedge clock);
        check("reset_outputs", {scl_o, sda_o, fifo_rdreq, busy, done, nack}, 6'b110000);
        sclr = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_outputs", {scl_o, sda_o, fifo_rdreq, busy, done, nack}, 6'b110000);

        for (int v = 0; v < 4; v++) run_vec(vecs[v]);

        // Reset mid-DATA (bit 4 of first data byte): bus released at once, only one pop taken.
        tail = head;
        fifo_push(8'hDE);
        fifo_push(8'hAD);
        nack_at = -1;
        exp_q.push_back(8'h66);
        snap();
        pulse_start(7'h33);
        begin
            int k;
            k = 0;
            while (rdreq_cnt == s_rd && k < 3000) begin
                @(negedge clock);
                k++;
            end
            check("rst_reach_data", (k < 3000), 1);
        end
        repeat (34) @(negedge clock);
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0;
        check("rst_mid_outputs", {scl_o, sda_o, fifo_rdreq, busy, done, nack}, 6'b110000);
        check("rst_mid_rdreq", rdreq_cnt - s_rd, 1);
        repeat (4) @(negedge clock);
        check("rst_mid_no_done", done_cnt - s_done, 0);
        compare_bytes("rst_mid");
        tail = head;
        fifo_push(8'h99);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h99);
        snap();
        pulse_start(7'h55);
        wait_done("post_rst");
        compare_bytes("post_rst");
        check("post_rst_starts", start_cnt - s_start, 1);
        check("post_rst_stops", stop_cnt - s_stop, 1);
        check("post_rst_rdreq", rdreq_cnt - s_rd, 1);
        check("post_rst_nack", nack, 1'b0);

        // Second start while busy must be ignored, including its address.
        tail = head;
        fifo_push(8'h77);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h77);
        snap();
        pulse_start(7'h10);
        repeat (10) @(negedge clock);
        check("restart_busy", busy, 1'b1);
        pulse_start(7'h7F);
        wait_done("restart");
        compare_bytes("restart");
        check("restart_starts", start_cnt - s_start, 1);
        check("restart_done_cnt", done_cnt - s_done, 1);
        repeat (10) @(negedge clock);
        check("restart_stays_idle", busy, 1'b0);
        check("restart_single_start", start_cnt - s_start, 1);

        check("fifo_underflow", underflow_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/i2c_fifo_tx.md
I2C_FIFO_TX -- requirements
Module: i2c_fifo_tx

Interface
REQ-001 SHALL have parameter QDIV, default 63, meaning clock cycles per quarter SCL bit period; legal range 2..255.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sclr  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a write transaction; sampled only in IDLE.
REQ-005 SHALL have port addr  input  7  target address; latched when start is accepted.
REQ-006 SHALL have port fifo_q  input  8  show-ahead FIFO head byte, valid whenever fifo_empty=0.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_rdreq  output  1  one-cycle pop strobe to the FIFO.
REQ-009 SHALL have port scl_o  output  1  SCL drive; 1=released, 0=pull low.
REQ-010 SHALL have port sda_o  output  1  SDA drive; 1=released, 0=pull low.
REQ-011 SHALL have port sda_i  input  1  sampled SDA line level.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on return to IDLE after STOP.
REQ-014 SHALL have port nack  output  1  sticky; set on any NACK, cleared on accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP.
REQ-016 SHALL time all bus phases with a quarter counter counting 0..QDIV-1; a phase ends when the counter reaches QDIV-1.
REQ-017 SHALL in IDLE hold scl_o=1, sda_o=1, fifo_rdreq=0; start=1 moves to START next cycle, latches addr, clears nack.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL drive START as two phases: (SCL=1,SDA=1), then (SCL=1,SDA=0); then enter ADDR.
REQ-020 SHALL shift each bit as four phases P0..P3: P0 SCL=0 with SDA set to the bit at P0 entry; P1,P2 SCL=1; P3 SCL=0; SDA stable P1..P3.
REQ-021 SHALL send in ADDR the byte {addr,1'b0} MSB first, 8 bit cells.
REQ-022 SHALL in ADDR_ACK and DATA_ACK release SDA for one bit cell and sample sda_i on the last clock of P1; 0=ACK, 1=NACK.
REQ-023 SHALL on ADDR ACK go to LOAD; on NACK set nack and go to STOP.
REQ-024 SHALL in LOAD, spending exactly one clock: if fifo_empty=0, assert fifo_rdreq for that cycle, latch fifo_q into the shift register, go to DATA; if fifo_empty=1, go to STOP with no rdreq.
REQ-025 SHALL send in DATA the latched byte MSB first, 8 bit cells; later FIFO changes do not affect it.
REQ-026 SHALL on DATA ACK go to LOAD; on NACK set nack and go to STOP; the NACKed byte is not re-sent.
REQ-027 SHALL drive STOP as three phases: (SCL=0,SDA=0), (SCL=1,SDA=0), (SCL=1,SDA=1); then go to IDLE with done=1 for that one cycle.
REQ-028 SHALL assert fifo_rdreq only in LOAD with fifo_empty=0; at most one pop per byte transmitted.
REQ-029 SHALL treat a FIFO that fills during STOP as untouched; bytes wait for the next start.
REQ-030 SHALL hold busy=1 from the cycle after start acceptance through the last STOP phase.

Reset
REQ-031 SHALL on sclr=1 at a clock edge enter IDLE, clear counters, shift and bit registers, and drive scl_o=1, sda_o=1, fifo_rdreq=0, busy=0, done=0, nack=0 from the next cycle.
REQ-032 SHALL let sclr override start and every in-flight state, including mid-bit and mid-STOP, with no STOP emitted and no pop issued.

Verification
REQ-033 SHALL cover this scenario: QDIV=2, FIFO holds 0xA5 then 0x3C, addr=0x50, start pulse, sda_i=0 at ACK slots -> SDA bits 0xA0, 0xA5, 0x3C; 2 rdreq pulses; STOP; done pulse; nack=0.
REQ-034 SHALL cover this scenario: addr=0x21, sda_i=1 at address ACK -> nack=1, STOP immediately after ACK cell, zero rdreq, done pulse.
REQ-035 SHALL cover this scenario: FIFO empty at start -> address byte 0x42 for addr=0x21, ACK, STOP, zero rdreq.
REQ-036 SHALL cover this scenario: 3 bytes queued, NACK on byte 2 -> 2 rdreq, STOP, nack=1, byte 3 remains in FIFO.
REQ-037 SHALL cover this scenario: sclr=1 during DATA bit 4 -> next cycle scl_o=1, sda_o=1, busy=0; a subsequent start runs a clean transaction.
REQ-038 SHALL cover this scenario: start pulsed again while busy -> ignored; exactly one START condition observed on the bus.
